corelet_seq: RTL and testbench
==============================

# corelet_seq

Instruction sequencer that drives the corelet's 34-bit `inst` bus for one full tile: fetch `row` weight words from activation/weight SRAM into L0, load them into the MAC array, stream `len` activation vectors through L0 into the array, then pop the OFIFO and write each psum vector to psum SRAM. It is the initiator on the instruction interface the corelet responds to. It sits between the top-level testbench/host start handshake and the corelet plus its two SRAMs.

## Interface
Parameters:
- row, 8, MAC array rows; also the number of weight words loaded into L0 per tile
- col, 8, MAC array columns; sets the kernel-propagation gap
- len_bw, 8, width of the activation count
- timeout, 64, maximum idle DRAIN cycles with `ofifo_valid` low before abort

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  one-cycle request; sampled in IDLE only, ignored otherwise
- w_base  in  11  xmem address of the first weight word
- x_base  in  11  xmem address of the first activation word
- p_base  in  11  pmem address of the first psum write
- len  in  len_bw  number of activation vectors (0..255)
- ofifo_valid  in  1  corelet OFIFO holds a complete row
- inst  out  34  corelet instruction word, registered
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal tile completion
- err  out  1  sticky timeout flag; cleared by the next accepted `start`

## Operation
inst field map (all bits registered; unlisted bits driven 0):
- [0] kernel load, [1] execute; at most one is high in any cycle
- [2] L0 write, [3] L0 read, [6] OFIFO read
- [16:7] xmem address, low 10 bits of the 11-bit base plus offset; [17] xmem CEN, active-low; [18] xmem WEN, active-low, always 1 (read-only)
- [29:19] pmem address; [30] pmem CEN, active-low; [31] pmem WEN, active-low
- [32] reserved 0; [33] SFP valid, always 0 (accumulation is controlled outside this block)

States and transitions:
- IDLE: on `start`, latch w_base, x_base, p_base and len, clear `err`, and go to WFETCH.
- WFETCH, `row`+1 cycles: cycles 0..row-1 drive CEN=0 with addr=w_base+k. Cycles 1..row assert L0 write, because xmem has 1-cycle read latency. Then go to KLOAD.
- KLOAD, `row` cycles: assert L0 read and kernel load. Then go to KGAP.
- KGAP, `col` cycles of NOP (inst=idle word). Then go to XFETCH, or to DONE directly if len==0.
- XFETCH, len+1 cycles: same pattern as WFETCH, using x_base and len.
- XEXEC, len cycles: assert L0 read and execute. Then go to DRAIN.
- DRAIN: stay until the pop count reaches len, then go to DONE.
- DONE, 1 cycle: pulse `done`, then go to IDLE.

OFIFO draining:
- Active in XEXEC and DRAIN.
- inst[6] = ofifo_valid & (pop_cnt < len). pop_cnt increments on each asserted pop.
- On the cycle after a pop, drive pmem CEN=0, WEN=0 and addr=p_base+wr_cnt, then increment wr_cnt.
- DRAIN exits only after the last pmem write has been issued.

Idle word: CEN=1, WEN=1, all enables 0, addresses 0.

Arithmetic:
- Address offsets add modulo 2^11 (xmem field truncated to 10 bits); wrap-around is legal and not flagged.
- Counters are len_bw+1 bits wide so that the count can reach len=255 without overflow.

## Timing
- Reset values: inst = idle word, busy=0, done=0, err=0, state=IDLE, all counters 0.
- Assertion of `reset` mid-tile aborts immediately to reset values. The corelet may hold partial state; the host must reset the corelet too.
- `start` accepted in cycle t gives busy=1 and the first xmem read in inst at t+1.
- Total latency, start edge to `done`, is 1 + (row+1) + row + col + (len+1) + len + drain + 1 cycles, where drain is at least 1 when len>0.
- len==0: KGAP → DONE. No execute, L0 write from activations, OFIFO read or pmem write is ever issued.
- Timeout: if DRAIN sees `timeout` consecutive cycles with ofifo_valid low, set `err` and return to IDLE with no `done` pulse.
- `start` while busy has no effect. `start` in the same cycle as the DONE→IDLE transition is ignored; it is accepted only once the block is in IDLE.

## Test plan
- Reset mid-WFETCH: assert reset at cycle 3 → inst = idle word the same cycle, and busy=0.
- Default tile with len=8 and a corelet model returning ofifo_valid 5 cycles after each execute:
  - exactly 8 L0 writes at w_base..w_base+7, then 8 kernel-load cycles and 8 NOP cycles
  - 8 execute cycles, 8 pops and 8 pmem writes at p_base..p_base+7
  - `done` pulses once
- len=0 → `done` at cycle 1+9+8+8+1 = 27 after start; no inst[1], inst[6] or pmem-write assertion is seen.
- p_base=0x7FE with len=4 → pmem addresses 0x7FE, 0x7FF, 0x000, 0x001.
- ofifo_valid held low in DRAIN → err=1 after exactly 64 cycles and busy drops with no `done`. The next `start` clears err.
- OFIFO back-pressure: ofifo_valid toggles 1-0-1-0 during XEXEC → each pop is followed by a pmem write on the next cycle, and pop_cnt never exceeds len.

Source files
------------

// File: rtl/corelet_seq.sv
`default_nettype none
// ============================================================================
// Module   : corelet_seq
// Brief    : Tile sequencer driving the corelet instruction bus: weight fetch,
//            kernel load, activation stream and OFIFO-to-psum-SRAM drain.
// Revision : 1.0
// ============================================================================
module corelet_seq #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int LEN_BW  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [10:0]       w_base,
    input  logic [10:0]       x_base,
    input  logic [10:0]       p_base,
    input  logic [LEN_BW-1:0] len,
    input  logic              ofifo_valid,
    output logic [33:0]       inst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WFETCH = 3'd1,
        S_KLOAD  = 3'd2,
        S_KGAP   = 3'd3,
        S_XFETCH = 3'd4,
        S_XEXEC  = 3'd5,
        S_DRAIN  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam int          c_CW_RC     = $clog2(ROW + COL + 2);
    localparam int          c_CW        = (LEN_BW + 1 > c_CW_RC) ? LEN_BW + 1 : c_CW_RC;
    localparam int          c_TW        = $clog2(TIMEOUT + 1);
    localparam logic [33:0] c_IDLE_WORD = 34'h0C0060000;
    localparam logic [LEN_BW:0] c_ONE_L = 1;

    state_t            r_state, w_state_nxt;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc, w_len_ext, w_fetch_n;
    logic [10:0]       r_w_base, r_x_base, r_p_base;
    logic [LEN_BW-1:0] r_len;
    logic [LEN_BW:0]   r_pop_cnt, r_wr_cnt;
    logic [c_TW-1:0]   r_idle, w_idle_nxt;
    logic              r_err, r_busy, r_done;
    logic [33:0]       r_inst, w_inst_nxt;
    logic              w_accept, w_abort, w_pop, w_wr;
    logic [10:0]       w_fetch_base, w_xsum, w_psum;
    logic              w_unused;

    assign inst = r_inst;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_cnt_inc = r_cnt + c_CW'(1);
    assign w_len_ext = c_CW'(r_len);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_idle_nxt  = '0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (start) w_state_nxt = S_WFETCH;
            end
            S_WFETCH: if (r_cnt == c_CW'(ROW)) begin
                w_state_nxt = S_KLOAD;
                w_cnt_nxt   = '0;
            end
            S_KLOAD: if (w_cnt_inc == c_CW'(ROW)) begin
                w_state_nxt = S_KGAP;
                w_cnt_nxt   = '0;
            end
            S_KGAP: if (w_cnt_inc == c_CW'(COL)) begin
                w_state_nxt = (r_len == '0) ? S_DONE : S_XFETCH;
                w_cnt_nxt   = '0;
            end
            S_XFETCH: if (r_cnt == w_len_ext) begin
                w_state_nxt = S_XEXEC;
                w_cnt_nxt   = '0;
            end
            S_XEXEC: if (w_cnt_inc == w_len_ext) begin
                w_state_nxt = S_DRAIN;
                w_cnt_nxt   = '0;
            end
            S_DRAIN: begin
                w_cnt_nxt = '0;
                // Write count reaching len means the final psum write is already out.
                if (r_wr_cnt == {1'b0, r_len}) begin
                    w_state_nxt = S_DONE;
                end else if (!ofifo_valid) begin
                    w_idle_nxt = r_idle + c_TW'(1);
                    if (r_idle == c_TW'(TIMEOUT - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_abort     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_pop = ofifo_valid && (r_pop_cnt < {1'b0, r_len}) &&
                   ((w_state_nxt == S_XEXEC) || (w_state_nxt == S_DRAIN));
    assign w_wr  = r_inst[6];

    // First weight address comes straight from the port on the accepting edge.
    assign w_fetch_base = (w_state_nxt == S_XFETCH) ? r_x_base : (w_accept ? w_base : r_w_base);
    assign w_fetch_n    = (w_state_nxt == S_XFETCH) ? w_len_ext : c_CW'(ROW);
    assign w_xsum       = w_fetch_base + 11'(w_cnt_nxt);
    assign w_psum       = r_p_base + 11'(r_wr_cnt);
    assign w_unused     = w_xsum[10];

    always_comb begin
        w_inst_nxt = c_IDLE_WORD;
        case (w_state_nxt)
            S_WFETCH, S_XFETCH: begin
                if (w_cnt_nxt < w_fetch_n) begin
                    w_inst_nxt[17]   = 1'b0;
                    w_inst_nxt[16:7] = w_xsum[9:0];
                end
                if (w_cnt_nxt != '0) w_inst_nxt[2] = 1'b1;
            end
            S_KLOAD: begin
                w_inst_nxt[3] = 1'b1;
                w_inst_nxt[0] = 1'b1;
            end
            S_XEXEC: begin
                w_inst_nxt[3] = 1'b1;
                w_inst_nxt[1] = 1'b1;
            end
            default: ;
        endcase
        w_inst_nxt[6] = w_pop;
        if (w_wr) begin
            w_inst_nxt[31]    = 1'b0;
            w_inst_nxt[30]    = 1'b0;
            w_inst_nxt[29:19] = w_psum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idle    <= '0;
            r_inst    <= c_IDLE_WORD;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_w_base  <= '0;
            r_x_base  <= '0;
            r_p_base  <= '0;
            r_len     <= '0;
            r_pop_cnt <= '0;
            r_wr_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idle  <= w_idle_nxt;
            r_inst  <= w_inst_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_w_base  <= w_base;
                r_x_base  <= x_base;
                r_p_base  <= p_base;
                r_len     <= len;
                r_err     <= 1'b0;
                r_pop_cnt <= '0;
                r_wr_cnt  <= '0;
            end else begin
                if (w_pop)   r_pop_cnt <= r_pop_cnt + c_ONE_L;
                if (w_wr)    r_wr_cnt  <= r_wr_cnt + c_ONE_L;
                if (w_abort) r_err     <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_corelet_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_corelet_seq
// Brief    : Directed scoreboard bench for corelet_seq with a small corelet model.
// Revision : 1.0
// ============================================================================
module tb_corelet_seq;

    localparam int          ROW     = 8;
    localparam int          COL     = 8;
    localparam int          LEN_BW  = 8;
    localparam int          TIMEOUT = 64;
    localparam logic [33:0] IDLE_W  = 34'h0C0060000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [10:0]       w_base = '0, x_base = '0, p_base = '0;
    logic [LEN_BW-1:0] len = '0;
    logic              ofifo_valid = 1'b0;
    logic [33:0]       inst;
    logic              busy, done, err;

    always #5 clk = ~clk;

    corelet_seq #(.ROW(ROW), .COL(COL), .LEN_BW(LEN_BW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .p_base(p_base), .len(len),
        .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard queues filled at stimulus time, drained by the monitor.
    logic [9:0]  q_rd[$];
    logic [10:0] q_pm[$];
    int          q_ready[$];
    int          mode = 0;
    int          cyc = 0, avail = 0;
    logic        prev_pop = 1'b0, in_gap = 1'b0, pm_wr;
    int          n_l0w = 0, n_kl = 0, n_ex = 0, n_pop = 0, n_pw = 0, n_done = 0;
    int          post = 0, gap = -1, gap_run = 0;

    // Monitor and corelet model: executes return OFIFO rows 5 cycles later.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            avail = 0;
            q_ready.delete();
            prev_pop = 1'b0;
            ofifo_valid = 1'b0;
        end else begin
            chk("fixed_bits", {60'd0, inst[33:32], inst[18], inst[0] & inst[1]}, 64'h2);
            if (!inst[17]) begin
                chk("xmem_read_expected", q_rd.size() > 0, 1);
                if (q_rd.size() > 0) chk("xmem_addr", inst[16:7], q_rd.pop_front());
            end
            pm_wr = !inst[30] && !inst[31];
            chk("pop_then_pmem_write", pm_wr, prev_pop);
            if (pm_wr) begin
                n_pw++;
                chk("pmem_write_expected", q_pm.size() > 0, 1);
                if (q_pm.size() > 0) chk("pmem_addr", inst[29:19], q_pm.pop_front());
            end
            if (inst[2]) n_l0w++;
            if (inst[0]) n_kl++;
            if (inst[6]) begin
                n_pop++;
                chk("pop_with_data", avail > 0, 1);
                if (avail > 0) avail--;
            end
            prev_pop = inst[6];
            if (inst[1]) begin
                n_ex++;
                q_ready.push_back(cyc + 5);
                post = 0;
            end else if (busy) begin
                post++;
            end
            if (inst[0]) begin
                in_gap = 1'b1;
                gap_run = 0;
                gap = -1;
            end else if (in_gap) begin
                if (inst == IDLE_W) gap_run++;
                else begin
                    gap = gap_run;
                    in_gap = 1'b0;
                end
            end
            if (done) n_done++;
            while (q_ready.size() > 0 && q_ready[0] <= cyc) begin
                void'(q_ready.pop_front());
                avail++;
            end
            if (mode == 2)      ofifo_valid = 1'b0;
            else if (mode == 1) ofifo_valid = (avail > 0) && cyc[0];
            else                ofifo_valid = (avail > 0);
        end
    end

    task automatic push_expected(input logic [10:0] wb, input logic [10:0] xb,
                                 input logic [10:0] pb, input int n, input int md);
        logic [10:0] a;
        for (int k = 0; k < ROW; k++) begin
            a = wb + 11'(k);
            q_rd.push_back(a[9:0]);
        end
        for (int k = 0; k < n; k++) begin
            a = xb + 11'(k);
            q_rd.push_back(a[9:0]);
        end
        if (md != 2)
            for (int k = 0; k < n; k++) q_pm.push_back(pb + 11'(k));
    endtask

    task automatic run_tile(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                            input int n, input int md, input bit extra);
        int  s_l0w, s_kl, s_ex, s_pop, s_pw, s_done, i, lat;
        bit  fin;
        mode = md;
        push_expected(wb, xb, pb, n, md);
        s_l0w = n_l0w; s_kl = n_kl; s_ex = n_ex; s_pop = n_pop; s_pw = n_pw; s_done = n_done;
        w_base = wb; x_base = xb; p_base = pb; len = n[LEN_BW-1:0];
        start = 1'b1;
        i = 0; fin = 0; lat = 0;
        while (!fin && i < 3000) begin
            @(negedge clk);
            i++;
            if (i == 1) begin
                start = 1'b0;
                chk("busy_after_start", busy, 1);
                chk("err_cleared_by_start", err, 0);
            end
            if (extra && i == 5) start = 1'b1;
            if (extra && i == 6) start = 1'b0;
            if (done || !busy) begin
                fin = 1;
                lat = i + 1;
            end
        end
        chk("tile_finished", fin, 1);
        if (extra && done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("start_in_done_ignored", busy, 0);
        end
        repeat (2) @(negedge clk);
        #1;
        chk("done_pulses", n_done - s_done, (md == 2) ? 0 : 1);
        chk("err_flag", err, md == 2);
        chk("busy_end", busy, 0);
        chk("l0_writes", n_l0w - s_l0w, ROW + n);
        chk("kernel_loads", n_kl - s_kl, ROW);
        chk("executes", n_ex - s_ex, n);
        chk("pops", n_pop - s_pop, (md == 2) ? 0 : n);
        chk("pmem_writes", n_pw - s_pw, (md == 2) ? 0 : n);
        chk("xmem_reads_left", q_rd.size(), 0);
        chk("pmem_writes_left", q_pm.size(), 0);
        if (n > 0)   chk("kernel_gap", gap, COL);
        if (n == 0)  chk("latency_len0", lat, 1 + (ROW + 1) + ROW + COL + 1);
        if (md == 2) chk("drain_timeout_cycles", post, TIMEOUT);
        q_rd.delete();
        q_pm.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_inst", inst, IDLE_W);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Abort mid weight-fetch
        push_expected(11'h123, 11'h0, 11'h0, 4, 0);
        w_base = 11'h123; x_base = '0; p_base = '0; len = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_mid_wfetch", busy, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_inst", inst, IDLE_W);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        q_rd.delete();
        q_pm.delete();
        repeat (2) @(negedge clk);

        run_tile(11'h010, 11'h100, 11'h200, 8,   0, 1'b1);
        run_tile(11'h3FC, 11'h000, 11'h000, 0,   0, 1'b0);
        run_tile(11'h020, 11'h7FD, 11'h7FE, 4,   1, 1'b0);
        run_tile(11'h040, 11'h050, 11'h060, 3,   2, 1'b0);
        run_tile(11'h070, 11'h080, 11'h090, 2,   0, 1'b0);
        run_tile(11'h5F0, 11'h600, 11'h400, 255, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
